if_prefetch: RTL and testbench

Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue. It issues sequential fetch requests to the I-cache ahead of demand and buffers returned instructions with their PCs. It presents buffered instructions to IF_ID under a valid/ready handshake. It redirects on EX jumps, discarding stale in-flight data, and stops issuing new fetches while MEM owns the memory controller.

---
 rtl/if_prefetch.sv | 134 +++++++++++++
 tb/tb_if_prefetch.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: issues sequential I-cache requests ahead of demand into a
// DEPTH-entry queue of {pc, inst}, presented to IF_ID with a valid/ready handshake.
module if_prefetch #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  jump_in,
   input  logic [ADDR_WIDTH-1:0] jumpTarget_in,
   input  logic                  memAccess_in,
   output logic                  icReq_out,
   output logic [ADDR_WIDTH-1:0] icAddr_out,
   input  logic                  icValid_in,
   input  logic [31:0]           icInst_in,
   output logic                  instE_out,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic [31:0]           inst_out,
   input  logic                  idReady_in,
   output logic                  ifStall_out
);

   // Handshake: the head transfers to IF_ID on an edge where instE_out and idReady_in
   // are both 1 (and rdy_in=1); instE_out never depends on idReady_in.

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  req_q, req_d;
   logic                  drop_q, drop_d;
   logic [PW-1:0]         head_q, head_d;
   logic [PW-1:0]         tail_q, tail_d;
   logic [CW-1:0]         count_q, count_d;

   logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
   logic [31:0]           inst_mem [DEPTH];

   logic          resp;
   logic          inst_e;
   logic          pop;
   logic          push;
   logic          issue;
   logic [CW-1:0] count_post;

   assign resp       = icValid_in & req_q;
   assign inst_e     = rst_in & ~jump_in & (count_q != '0);
   assign pop        = inst_e & idReady_in;
   assign push       = resp & ~drop_q & ~jump_in;
   assign count_post = count_q + CW'(push) - CW'(pop);
   // The new request reserves a queue slot, so its response can never overflow.
   assign issue      = ~jump_in & ~memAccess_in & ~drop_q & (~req_q | resp) &
                       (count_post < DEPTH_C);

   always_comb begin
      fpc_d   = fpc_q;
      addr_d  = addr_q;
      req_d   = req_q;
      drop_d  = drop_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (rdy_in) begin
         if (jump_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            fpc_d   = jumpTarget_in;
            if (resp) begin
               req_d  = 1'b0;
               addr_d = '0;
               drop_d = 1'b0;
            end else if (req_q) begin
               drop_d = 1'b1;
            end
         end else begin
            if (pop)  head_d = head_q + PW'(1);
            if (push) tail_d = tail_q + PW'(1);
            count_d = count_post;
            if (resp && drop_q) begin
               drop_d = 1'b0;
               req_d  = 1'b0;
               addr_d = '0;
            end else if (issue) begin
               req_d  = 1'b1;
               addr_d = fpc_q;
               fpc_d  = fpc_q + ADDR_WIDTH'(4);
            end else if (resp) begin
               req_d  = 1'b0;
               addr_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         fpc_q   <= RESET_PC;
         addr_q  <= '0;
         req_q   <= 1'b0;
         drop_q  <= 1'b0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         fpc_q   <= fpc_d;
         addr_q  <= addr_d;
         req_q   <= req_d;
         drop_q  <= drop_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in && rdy_in && push) begin
         pc_mem[tail_q]   <= addr_q;
         inst_mem[tail_q] <= icInst_in;
      end
   end

   assign icReq_out   = req_q;
   assign icAddr_out  = addr_q;
   assign instE_out   = inst_e;
   assign pc_out      = inst_e ? pc_mem[head_q] : '0;
   assign inst_out    = inst_e ? inst_mem[head_q] : '0;
   assign ifStall_out = rst_in & (count_q == '0);

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_if_prefetch;

   localparam int AW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rdy = 1'b1;
   logic          jump = 1'b0;
   logic [AW-1:0] jt = '0;
   logic          mem = 1'b0;
   logic          icv = 1'b0;
   logic [31:0]   icinst = '0;
   logic          idr = 1'b0;
   logic          ic_req;
   logic [AW-1:0] ic_addr;
   logic          inst_e;
   logic [AW-1:0] pc;
   logic [31:0]   inst;
   logic          stall;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   if_prefetch #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
      .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .jump_in(jump),
      .jumpTarget_in(jt), .memAccess_in(mem), .icReq_out(ic_req),
      .icAddr_out(ic_addr), .icValid_in(icv), .icInst_in(icinst),
      .instE_out(inst_e), .pc_out(pc), .inst_out(inst),
      .idReady_in(idr), .ifStall_out(stall)
   );

   // Model: the queue holds delivered {pc, inst}; the request is a single slot.
   typedef struct {
      logic [AW-1:0] pc;
      logic [31:0]   inst;
   } ent_t;

   ent_t          mq[$];
   logic [AW-1:0] m_fpc  = '0;
   logic          m_req  = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic          m_drop = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      logic          e_ie;
      logic [AW-1:0] e_pc;
      logic [31:0]   e_inst;
      e_ie   = rst && !jump && (mq.size() != 0);
      e_pc   = e_ie ? mq[0].pc : '0;
      e_inst = e_ie ? mq[0].inst : '0;
      chk("icReq", 32'(ic_req), 32'(m_req));
      chk("icAddr", ic_addr, m_addr);
      chk("instE", 32'(inst_e), 32'(e_ie));
      chk("pc", pc, e_pc);
      chk("inst", inst, e_inst);
      chk("ifStall", 32'(stall), 32'(rst && (mq.size() == 0)));
   endtask

   task automatic model_update();
      logic resp;
      ent_t e;
      if (!rst) begin
         mq.delete();
         m_fpc = '0; m_req = 1'b0; m_addr = '0; m_drop = 1'b0;
      end else if (rdy) begin
         resp = icv && m_req;
         if (jump) begin
            mq.delete();
            m_fpc = jt;
            if (resp) begin
               m_req = 1'b0; m_addr = '0; m_drop = 1'b0;
            end else if (m_req) begin
               m_drop = 1'b1;
            end
         end else begin
            if (mq.size() != 0 && idr) mq.delete(0);
            if (resp && m_drop) begin
               m_drop = 1'b0; m_req = 1'b0; m_addr = '0;
            end else begin
               if (resp) begin
                  e.pc = m_addr; e.inst = icinst;
                  mq.push_back(e);
               end
               if (!mem && !m_drop && (!m_req || resp) && mq.size() < DEPTH) begin
                  m_req = 1'b1; m_addr = m_fpc; m_fpc = m_fpc + 32'd4;
               end else if (resp) begin
                  m_req = 1'b0; m_addr = '0;
               end
            end
         end
      end
   endtask

   // Called at a falling edge with inputs set; returns at the next falling edge.
   task automatic cycle();
      #1;
      compare();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      rdy = 1'b1; jump = 1'b0; jt = '0; mem = 1'b0; icv = 1'b0; idr = 1'b0;
      icinst = $urandom;
   endtask

   task automatic reset_dut();
      idle_inputs();
      rst = 1'b0;
      cycle();
      rst = 1'b1;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_icReq", 32'(ic_req), 32'd0);
      chk("reset_stall", 32'(stall), 32'd0);
      cycle();
      rst = 1'b1;

      // Streaming with a 1-cycle cache and IF_ID always ready.
      for (int i = 0; i < 4; i++) begin
         icv = m_req; icinst = $urandom; idr = 1'b1;
         cycle();
         chk("stream_addr", ic_addr, 32'(i * 4));
         if (i > 0) chk("stream_pc", pc, 32'((i - 1) * 4));
      end

      // Fill with IF_ID stalled: exactly DEPTH entries, then drain and resume.
      reset_dut();
      for (int i = 0; i < 8; i++) begin
         icv = m_req; icinst = $urandom; idr = 1'b0;
         cycle();
      end
      chk("fill_no_req", 32'(ic_req), 32'd0);
      chk("fill_stall", 32'(stall), 32'd0);
      chk("fill_head", pc, 32'h0);
      for (int i = 0; i < 4; i++) begin
         icv = m_req; icinst = $urandom; idr = 1'b1;
         cycle();
         if (i == 0) chk("resume_addr", ic_addr, 32'h10);
         if (i < 3) chk("drain_pc", pc, 32'((i + 1) * 4));
      end

      // Jump with a request outstanding; the stale response arrives later.
      reset_dut();
      icv = 1'b0; cycle();
      chk("j_addr0", ic_addr, 32'h0);
      jump = 1'b1; jt = 32'h100; cycle();
      chk("j_hold", 32'(ic_req), 32'd1);
      jump = 1'b0; icv = 1'b1; icinst = 32'hdead_beef; cycle();
      chk("j_dropped", 32'(ic_req), 32'd0);
      chk("j_nodata", 32'(inst_e), 32'd0);
      icv = 1'b0; cycle();
      chk("j_target", ic_addr, 32'h100);
      icv = 1'b1; icinst = $urandom; cycle();
      chk("j_first_pc", pc, 32'h100);

      // Jump on the same edge as a response.
      reset_dut();
      cycle();
      jump = 1'b1; jt = 32'h200; icv = 1'b1; cycle();
      chk("js_req", 32'(ic_req), 32'd0);
      jump = 1'b0; icv = 1'b0; cycle();
      chk("js_target", ic_addr, 32'h200);

      // memAccess blocks issue while the queue drains.
      reset_dut();
      for (int i = 0; i < 6; i++) begin
         icv = m_req; icinst = $urandom; cycle();
      end
      mem = 1'b1; idr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         icv = m_req; cycle();
      end
      chk("mem_stall", 32'(stall), 32'd1);
      chk("mem_noreq", 32'(ic_req), 32'd0);
      mem = 1'b0; cycle();
      chk("mem_resume", ic_addr, 32'h10);

      // Freeze with rdy low, then reset mid-stream.
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         icv = m_req; cycle();
      end
      chk("frz_addr", ic_addr, 32'h10);
      rdy = 1'b1; rst = 1'b0; cycle();
      rst = 1'b1;
      chk("rst_req", 32'(ic_req), 32'd0);
      mem = 1'b0; icv = 1'b0; cycle();
      chk("rst_first", ic_addr, 32'h0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rst    = ($urandom_range(0, 199) != 0);
         rdy    = ($urandom_range(0, 9) != 0);
         jump   = ($urandom_range(0, 15) == 0);
         jt     = {$urandom_range(0, 255), 2'b00};
         mem    = ($urandom_range(0, 7) == 0);
         icv    = m_req && ($urandom_range(0, 2) != 0);
         icinst = $urandom;
         idr    = ($urandom_range(0, 3) != 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
